// File: rtl/field_line_clear.sv
// Field line-clear engine: removes full rows from a field snapshot and shifts the rows above them down, one row per clock.
// Optional scoring is enabled with the LINE_CLEAR_SCORE_EN macro.
module field_line_clear #(
    parameter int FIELD_VERTICAL   = 22,
    parameter int FIELD_HORIZONTAL = 10,
    parameter int CELL_W           = 3
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic [FIELD_VERTICAL*FIELD_HORIZONTAL*CELL_W-1:0]   f_in,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [FIELD_VERTICAL*FIELD_HORIZONTAL*CELL_W-1:0]   f_out,
    output logic [$clog2(FIELD_VERTICAL+1)-1:0]                  lines_cleared,
    output logic [19:0]                                          score
);

    localparam int ROW_W   = FIELD_HORIZONTAL * CELL_W;
    localparam int FIELD_W = FIELD_VERTICAL * ROW_W;
    localparam int PTR_W   = $clog2(FIELD_VERTICAL);
    localparam int CNT_W   = $clog2(FIELD_VERTICAL + 1);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(FIELD_VERTICAL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, FINISH} state_t;

    state_t             state;
    state_t             state_next;
    logic [FIELD_W-1:0] work;
    logic [PTR_W-1:0]   rd;
    logic [PTR_W-1:0]   wr;
    logic [CNT_W-1:0]   k;
    logic [ROW_W-1:0]   rd_row;
    logic               row_full;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A row is full only when every cell holds a nonzero colour.
    always_comb begin
        state_next = state;
        rd_row     = work[rd*ROW_W +: ROW_W];
        row_full   = 1'b1;
        for (int c = 0; c < FIELD_HORIZONTAL; c++) begin
            if (rd_row[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
        end
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (rd == '0) state_next = ((k != '0) || row_full) ? FILL : FINISH;
            FILL:    if (wr == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointers stop at row 0 instead of wrapping; the state change happens on the last row.
    always_ff @(posedge clk) begin
        if (reset) begin
            work          <= '0;
            rd            <= '0;
            wr            <= '0;
            k             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            f_out         <= '0;
            lines_cleared <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= f_in;
                        rd   <= LAST_ROW;
                        wr   <= LAST_ROW;
                        k    <= '0;
                        busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        k <= k + 1'b1;
                    end else begin
                        work[wr*ROW_W +: ROW_W] <= rd_row;
                        if (wr != '0) wr <= wr - 1'b1;
                    end
                    if (rd != '0) rd <= rd - 1'b1;
                end
                FILL: begin
                    work[wr*ROW_W +: ROW_W] <= '0;
                    if (wr != '0) wr <= wr - 1'b1;
                end
                FINISH: begin
                    f_out         <= work;
                    lines_cleared <= k;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0] score_add;
    logic [20:0] score_sum;

    // Clears beyond four rows are only possible with custom fields and score like a four-line clear.
    always_comb begin
        score_add = 20'd0;
        case (k)
            CNT_W'(0): score_add = 20'd0;
            CNT_W'(1): score_add = 20'd100;
            CNT_W'(2): score_add = 20'd300;
            CNT_W'(3): score_add = 20'd500;
            default:   score_add = 20'd800;
        endcase
        score_sum = {1'b0, score} + {1'b0, score_add};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score <= '0;
        end else if (state == FINISH) begin
            score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_field_line_clear.sv
// Directed self-checking bench for field_line_clear; score expectations follow LINE_CLEAR_SCORE_EN.
module tb_field_line_clear;

    localparam int V  = 22;
    localparam int H  = 10;
    localparam int W  = 3;
    localparam int RW = H * W;
    localparam int FW = V * RW;
    localparam int CW = $clog2(V + 1);

    logic          clk;
    logic          reset;
    logic          start;
    logic [FW-1:0] f_in;
    logic          busy;
    logic          done;
    logic [FW-1:0] f_out;
    logic [CW-1:0] lines_cleared;
    logic [19:0]   score;

    int compare_cnt = 0;
    int fail_cnt    = 0;
    int exp_score   = 0;

    logic [FW-1:0] fld_empty, fld_part, fld_one, exp_one, fld_multi, exp_multi, fld_full, f_snap;
    int            done_cnt, first_done, second_done;

    field_line_clear dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .f_in          (f_in),
        .busy          (busy),
        .done          (done),
        .f_out         (f_out),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [RW-1:0] full_row(input int colour);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < H; c++) r[c*W +: W] = W'(colour);
        return r;
    endfunction

    // Cells 0..8 get a seed-dependent nonzero colour, cell 9 stays empty.
    function automatic logic [RW-1:0] partial_row(input int seed);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < H - 1; c++) r[c*W +: W] = W'(((seed + c) % 7) + 1);
        return r;
    endfunction

    function automatic logic [FW-1:0] put_row(input logic [FW-1:0] f, input int row, input logic [RW-1:0] val);
        f[row*RW +: RW] = val;
        return f;
    endfunction

    function automatic int score_for(input int k);
        if (k == 0) return 0;
        if (k == 1) return 100;
        if (k == 2) return 300;
        if (k == 3) return 500;
        return 800;
    endfunction

    task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        compare_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [FW-1:0] fld);
        f_in  = fld;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic account_score(input int k);
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = exp_score + score_for(k);
        if (exp_score > 1048575) exp_score = 1048575;
`else
        exp_score = 0;
`endif
    endtask

    task automatic run_op(input string tag, input logic [FW-1:0] fld, input logic [FW-1:0] exp_f,
                          input int exp_k, input int exp_lat);
        int cyc;
        bit busy_ok;
        applyStimulus(fld);
        checkOutput({tag, " busy_at_accept"}, FW'(busy), FW'(1));
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        account_score(exp_k);
        checkOutput({tag, " latency"}, FW'(cyc), FW'(exp_lat));
        checkOutput({tag, " busy_held"}, FW'(busy_ok), FW'(1));
        checkOutput({tag, " busy_at_done"}, FW'(busy), FW'(0));
        checkOutput({tag, " lines_cleared"}, FW'(lines_cleared), FW'(exp_k));
        checkOutput({tag, " f_out"}, f_out, exp_f);
        checkOutput({tag, " score"}, FW'(score), FW'(exp_score));
        @(posedge clk);
        #1;
        checkOutput({tag, " done_one_cycle"}, FW'(done), FW'(0));
    endtask

    task automatic wait_done;
        int cyc;
        cyc = 0;
        while (cyc < 200 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        f_in  = '0;

        fld_empty = '0;
        fld_part  = '0;
        for (int r = 0; r < V; r++) fld_part = put_row(fld_part, r, partial_row(r));
        fld_one   = put_row('0, 21, full_row(3));
        fld_one   = put_row(fld_one, 20, {{(RW-W){1'b0}}, 3'd5});
        exp_one   = put_row('0, 21, {{(RW-W){1'b0}}, 3'd5});
        fld_multi = '0;
        fld_multi = put_row(fld_multi, 21, full_row(1));
        fld_multi = put_row(fld_multi, 19, full_row(2));
        fld_multi = put_row(fld_multi, 18, full_row(7));
        fld_multi = put_row(fld_multi, 10, full_row(4));
        fld_multi = put_row(fld_multi, 20, partial_row(1));
        fld_multi = put_row(fld_multi, 17, partial_row(2));
        fld_multi = put_row(fld_multi, 9,  partial_row(3));
        exp_multi = '0;
        exp_multi = put_row(exp_multi, 21, partial_row(1));
        exp_multi = put_row(exp_multi, 20, partial_row(2));
        exp_multi = put_row(exp_multi, 13, partial_row(3));
        fld_full  = '0;
        for (int r = 0; r < V; r++) fld_full = put_row(fld_full, r, full_row((r % 7) + 1));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset busy", FW'(busy), FW'(0));
        checkOutput("reset done", FW'(done), FW'(0));
        checkOutput("reset f_out", f_out, FW'(0));
        checkOutput("reset lines", FW'(lines_cleared), FW'(0));
        checkOutput("reset score", FW'(score), FW'(0));

        run_op("empty", fld_empty, fld_empty, 0, 23);
        run_op("no_full", fld_part, fld_part, 0, 23);
        run_op("one_row", fld_one, exp_one, 1, 24);
        run_op("four_rows", fld_multi, exp_multi, 4, 27);
        run_op("all_full", fld_full, '0, 22, 45);

        // Extra start pulses and a changing f_in while busy must not disturb the operation.
        applyStimulus(fld_one);
        done_cnt   = 0;
        first_done = 0;
        f_snap     = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = cyc;
                    f_snap     = f_out;
                end
            end
            if (cyc == 3) f_in = fld_full;
            if (cyc == 4 || cyc == 9) start = 1'b1;
            if (cyc == 5 || cyc == 10) start = 1'b0;
        end
        account_score(1);
        checkOutput("busy_ignore latency", FW'(first_done), FW'(24));
        checkOutput("busy_ignore done_count", FW'(done_cnt), FW'(1));
        checkOutput("busy_ignore f_out", f_snap, exp_one);
        checkOutput("busy_ignore score", FW'(score), FW'(exp_score));

        // Start held through the done cycle launches the next operation immediately.
        applyStimulus(fld_part);
        done_cnt    = 0;
        first_done  = 0;
        second_done = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = cyc;
                    f_snap     = f_out;
                end else begin
                    second_done = cyc;
                end
            end
            if (cyc == 22) begin
                start = 1'b1;
                f_in  = fld_one;
            end
            if (cyc == 24) start = 1'b0;
        end
        account_score(0);
        account_score(1);
        checkOutput("b2b first_done", FW'(first_done), FW'(23));
        checkOutput("b2b first_f_out", f_snap, fld_part);
        checkOutput("b2b second_done", FW'(second_done), FW'(48));
        checkOutput("b2b done_count", FW'(done_cnt), FW'(2));
        checkOutput("b2b second_f_out", f_out, exp_one);
        checkOutput("b2b score", FW'(score), FW'(exp_score));

        // Reset in the middle of SCAN discards everything and no done follows.
        applyStimulus(fld_multi);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_score = 0;
        checkOutput("midreset busy", FW'(busy), FW'(0));
        checkOutput("midreset done", FW'(done), FW'(0));
        checkOutput("midreset f_out", f_out, FW'(0));
        checkOutput("midreset lines", FW'(lines_cleared), FW'(0));
        checkOutput("midreset score", FW'(score), FW'(0));
        reset    = 1'b0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("midreset no_done", FW'(done_cnt), FW'(0));

        run_op("score_one", fld_one, exp_one, 1, 24);
        run_op("score_four", fld_multi, exp_multi, 4, 27);
`ifdef LINE_CLEAR_SCORE_EN
        checkOutput("score 1+4", FW'(score), FW'(900));
        for (int i = 0; i < 1311; i++) begin
            applyStimulus(fld_multi);
            wait_done();
        end
        @(posedge clk);
        #1;
        checkOutput("score saturated", FW'(score), FW'(1048575));
`else
        checkOutput("score disabled", FW'(score), FW'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
        $finish;
    end

endmodule
